// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// The RS_DRAIN state is only reachable when RESET_SEQ_DRAIN_EN is defined.
package reset_seq_pkg;

    typedef enum logic [1:0] {RS_ASSERT, RS_RELEASE, RS_RUN, RS_DRAIN} reset_seq_state_t;

    // One counter serves every state, so it must hold the largest terminal count.
    function automatic int cntWidth(input int hold, input int stage, input int drain);
        int m;
        m = hold;
        if (stage > m) m = stage;
        if (drain > m) m = drain;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Holds all reset domains asserted, then releases them one by one at fixed intervals.
// Define RESET_SEQ_DRAIN_EN to add a drain handshake before a soft restart from RUN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N             = 1,
    parameter int HOLD_CYCLES   = 16,
    parameter int STAGE_DELAY   = 4,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         soft_req,
    output logic [N-1:0] reset_o,
    output logic         ready
`ifdef RESET_SEQ_DRAIN_EN
    ,
    output logic         drain_req,
    input  logic         drain_ack
`endif
);

    localparam int CNT_W = cntWidth(HOLD_CYCLES, STAGE_DELAY, DRAIN_TIMEOUT);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    reset_seq_state_t   state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N-1:0]       reset_q, reset_d;
    logic               ready_q, ready_d;
    logic               restart;
`ifdef RESET_SEQ_DRAIN_EN
    logic               drainReq_q, drainReq_d;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= RS_ASSERT;
            cnt_q      <= '0;
            idx_q      <= '0;
            reset_q    <= '1;
            ready_q    <= 1'b0;
`ifdef RESET_SEQ_DRAIN_EN
            drainReq_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            reset_q    <= reset_d;
            ready_q    <= ready_d;
`ifdef RESET_SEQ_DRAIN_EN
            drainReq_q <= drainReq_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        reset_d    = reset_q;
        ready_d    = ready_q;
        restart    = 1'b0;
`ifdef RESET_SEQ_DRAIN_EN
        drainReq_d = drainReq_q;
`endif
        case (state_q)
            RS_ASSERT: begin
                if (soft_req) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    reset_d[0] = 1'b0;
                    idx_d      = IDX_W'(1);
                    cnt_d      = '0;
                    if (N == 1) begin
                        state_d = RS_RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = RS_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RS_RELEASE: begin
                if (soft_req) begin
                    restart = 1'b1;
                end else if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
                    reset_d[idx_q] = 1'b0;
                    cnt_d          = '0;
                    idx_d          = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N - 1)) begin
                        state_d = RS_RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RS_RUN: begin
                if (soft_req) begin
`ifdef RESET_SEQ_DRAIN_EN
                    state_d    = RS_DRAIN;
                    drainReq_d = 1'b1;
                    cnt_d      = '0;
`else
                    restart = 1'b1;
`endif
                end
            end
            default: begin
`ifdef RESET_SEQ_DRAIN_EN
                // Outputs stay as in RUN while clients quiesce; soft_req is ignored here.
                if (drain_ack || (cnt_q == CNT_W'(DRAIN_TIMEOUT - 1))) begin
                    restart = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                restart = 1'b1;
`endif
            end
        endcase

        if (restart) begin
            state_d    = RS_ASSERT;
            cnt_d      = '0;
            idx_d      = '0;
            reset_d    = '1;
            ready_d    = 1'b0;
`ifdef RESET_SEQ_DRAIN_EN
            drainReq_d = 1'b0;
`endif
        end
    end

    assign reset_o = reset_q;
    assign ready   = ready_q;
`ifdef RESET_SEQ_DRAIN_EN
    assign drain_req = drainReq_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: a 3-domain and a 1-domain instance share stimulus.
// Follows RESET_SEQ_DRAIN_EN so the same bench covers both builds.
module tb_reset_sequencer;

    localparam int DT = 8;
`ifdef RESET_SEQ_DRAIN_EN
    localparam bit DRAIN_EN = 1'b1;
`else
    localparam bit DRAIN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       softReq;
    logic       drainAck;
    logic [2:0] resetA;
    logic       readyA;
    logic [0:0] resetB;
    logic       readyB;
    logic       drainReqA;
    logic       drainReqB;

    int checks = 0;
    int errors = 0;

    // Reference model: edges elapsed since the sequence last (re)started; domain i is
    // released once that count reaches hold + i*stage.
    int hold[2]  = '{4, 1};
    int stage[2] = '{2, 1};
    int nDom[2]  = '{3, 1};
    int elapsed[2];
    bit inDrain[2];
    int drainEdges[2];

    always #5 clk = ~clk;

    reset_sequencer #(.N(3), .HOLD_CYCLES(4), .STAGE_DELAY(2), .DRAIN_TIMEOUT(DT)) dutA (
        .clk(clk), .resetn(resetn), .soft_req(softReq), .reset_o(resetA), .ready(readyA)
`ifdef RESET_SEQ_DRAIN_EN
        , .drain_req(drainReqA), .drain_ack(drainAck)
`endif
    );

    reset_sequencer #(.N(1), .HOLD_CYCLES(1), .STAGE_DELAY(1), .DRAIN_TIMEOUT(DT)) dutB (
        .clk(clk), .resetn(resetn), .soft_req(softReq), .reset_o(resetB), .ready(readyB)
`ifdef RESET_SEQ_DRAIN_EN
        , .drain_req(drainReqB), .drain_ack(drainAck)
`endif
    );

`ifndef RESET_SEQ_DRAIN_EN
    assign drainReqA = 1'b0;
    assign drainReqB = 1'b0;
`endif

    function automatic int lastRelease(input int k);
        return hold[k] + (nDom[k] - 1) * stage[k];
    endfunction

    function automatic logic [2:0] expReset(input int k);
        logic [2:0] v;
        v = '0;
        for (int i = 0; i < nDom[k]; i++)
            v[i] = !inDrain[k] && (elapsed[k] < hold[k] + i * stage[k]);
        return v;
    endfunction

    task automatic modelEdge(input bit rn, input bit sr, input bit ack);
        for (int k = 0; k < 2; k++) begin
            if (!rn) begin
                elapsed[k] = 0;
                inDrain[k] = 1'b0;
            end else if (inDrain[k]) begin
                drainEdges[k]++;
                if (ack || drainEdges[k] == DT) begin
                    inDrain[k] = 1'b0;
                    elapsed[k] = 0;
                end
            end else if (sr) begin
                if (DRAIN_EN && elapsed[k] >= lastRelease(k)) begin
                    inDrain[k]    = 1'b1;
                    drainEdges[k] = 0;
                end else begin
                    elapsed[k] = 0;
                end
            end else if (elapsed[k] < 100000) begin
                elapsed[k]++;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then check at the falling edge.
    task automatic applyStimulus(input bit rn, input bit sr, input bit ack);
        resetn   = rn;
        softReq  = sr;
        drainAck = ack;
        @(posedge clk);
        modelEdge(rn, sr, ack);
        @(negedge clk);
        checkOutput("resetA", 32'(resetA), 32'(expReset(0)));
        checkOutput("readyA", 32'(readyA),
                    32'(inDrain[0] || elapsed[0] >= lastRelease(0)));
        checkOutput("resetB", 32'(resetB), 32'(expReset(1)));
        checkOutput("readyB", 32'(readyB),
                    32'(inDrain[1] || elapsed[1] >= lastRelease(1)));
        if (DRAIN_EN) begin
            checkOutput("drainReqA", 32'(drainReqA), 32'(inDrain[0]));
            checkOutput("drainReqB", 32'(drainReqB), 32'(inDrain[1]));
        end
    endtask

    initial begin
        resetn   = 1'b0;
        softReq  = 1'b0;
        drainAck = 1'b0;

        // Power-on hold, then full release sequence.
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
        // Soft restart from RUN.
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (12) applyStimulus(1'b1, 1'b0, 1'b0);
        // Soft restart in the middle of the release phase.
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
        // Hard reset mid-sequence, with a soft request that must be ignored.
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (12) applyStimulus(1'b1, 1'b0, 1'b0);
        // Soft request in RUN, acknowledged on the third cycle.
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (12) applyStimulus(1'b1, 1'b0, 1'b0);
        // Soft request in RUN that is never acknowledged.
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (20) applyStimulus(1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 1500; n++)
            applyStimulus(($urandom % 40) != 0, ($urandom % 10) == 0, ($urandom % 4) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
